// File: rtl/mem_access_ctrl.sv
// Request sequencer for the shared instruction/data memory port: one access per request,
// registered-read capture, valid/ready response. Optional MEMCTRL_ALIGN_CHECK_EN rejects misaligned/out-of-range addresses.
module mem_access_ctrl #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_irwrite,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_instr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [1:0] OP_FETCH = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    state_t     state_reg;
    logic [1:0] op_reg;
    logic       req_bad;

`ifdef MEMCTRL_ALIGN_CHECK_EN
    assign req_bad = (req_op == OP_RSVD) || (req_addr[1:0] != 2'b00) || (|req_addr[31:ADDR_W+2]);
`else
    assign req_bad = (req_op == OP_RSVD);
`endif

    assign req_ready = (state_reg == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            op_reg      <= OP_FETCH;
            mem_addr    <= '0;
            mem_wd      <= '0;
            mem_we      <= 1'b0;
            mem_irwrite <= 1'b0;
            resp_valid  <= 1'b0;
            resp_data   <= '0;
            resp_err    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        if (req_bad) begin
                            // Rejected requests skip the memory entirely and answer next cycle
                            resp_err   <= 1'b1;
                            resp_data  <= '0;
                            resp_valid <= 1'b1;
                            state_reg  <= RESP;
                        end else begin
                            op_reg      <= req_op;
                            mem_addr    <= req_addr[ADDR_W+1:2];
                            mem_we      <= (req_op == OP_STORE);
                            mem_irwrite <= (req_op == OP_FETCH);
                            if (req_op == OP_STORE) begin
                                mem_wd <= req_wdata;
                            end
                            state_reg <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    mem_we      <= 1'b0;
                    mem_irwrite <= 1'b0;
                    state_reg   <= CAPTURE;
                end
                CAPTURE: begin
                    // Memory outputs are registered, so they are valid only now
                    case (op_reg)
                        OP_FETCH: resp_data <= mem_instr;
                        OP_LOAD:  resp_data <= mem_rd;
                        default:  resp_data <= '0;
                    endcase
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state_reg  <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Request sequencer that drives the shared 128-word instruction/data memory port of the multicycle core. It accepts fetch, load and store requests from the datapath over a valid/ready handshake and issues single-cycle memory accesses (address, write-enable, instruction-register write strobe, write data). It captures the memory's registered read data or instruction one cycle later and returns it over a valid/ready response channel. It sits between the control/datapath and the memory, as the initiator of every memory transaction.

## Interface
- `ADDR_W`, 7: word-address width of the memory port (128 words).
- `DATA_W`, 32: data width.
- `clk` in 1: clock; every register updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_op` in 2: 00 fetch, 01 load, 10 store, 11 reserved.
- `req_addr` in 32: byte address.
- `req_wdata` in DATA_W: store data.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts the response.
- `resp_data` out DATA_W: fetched instruction or loaded word; 0 for a store or an error.
- `resp_err` out 1: request rejected; no memory access was made.
- `mem_addr` out ADDR_W: word address to memory.
- `mem_we` out 1: memory write enable.
- `mem_irwrite` out 1: instruction-register write strobe to memory.
- `mem_wd` out DATA_W: memory write data.
- `mem_rd` in DATA_W: memory registered read data.
- `mem_instr` in DATA_W: memory registered instruction output.

## Operation
- **States:** IDLE, ACCESS, CAPTURE, RESP.
- **Reset:** state IDLE. All outputs 0 except `req_ready`, which is 1 because it is decoded from IDLE.
- **`req_ready`:** 1 only in IDLE. Request inputs are sampled only on the accepting edge (`req_valid & req_ready`); they are don't-care at all other times.
- **IDLE, valid request accepted:** latch the op, latch `mem_addr = req_addr[ADDR_W+1:2]` and latch `mem_wd = req_wdata` (store only). Next state is ACCESS.
- **IDLE, reserved op (11) accepted:** no memory access. Latch `resp_err = 1` and `resp_data = 0`. Next state is RESP.
- **ACCESS, one cycle:**
  - Store: `mem_we = 1`.
  - Fetch: `mem_irwrite = 1`.
  - Load: neither strobe.
  - Next state is CAPTURE.
- **CAPTURE, one cycle:** memory outputs are valid.
  - Fetch: latch `resp_data = mem_instr`.
  - Load: latch `resp_data = mem_rd`.
  - Store: latch `resp_data = 0`.
  - `resp_err = 0`. Next state is RESP.
- **RESP:** `resp_valid = 1`. `resp_data` and `resp_err` are held stable until `resp_valid & resp_ready` at an edge, then the next state is IDLE.
- **Strobes:** `mem_we` and `mem_irwrite` are 0 outside ACCESS and are never both 1.
- **Held outputs:** `mem_addr` and `mem_wd` keep their last latched values between transactions.
- **Address range:** word addresses wrap modulo 2^ADDR_W unless checking is compiled in (see Configuration).
- **Outstanding requests:** at most one transaction is in flight. No request is accepted while a response is pending.

## Timing
- **Latency:** accept at edge E0. ACCESS is the cycle after E0. CAPTURE follows E1. `resp_valid` rises after E2, i.e. 3 edges after acceptance.
- **Error latency:** `resp_valid` rises 1 edge after acceptance.
- **Throughput:** at most one transaction per 4 cycles, because IDLE lasts at least one cycle after the response handshake.
- **Backpressure:** if `resp_ready` is held low, RESP persists indefinitely and `req_ready` stays 0.
- **Reset mid-operation:** `rst_n` low asynchronously forces IDLE and clears every output, including `mem_we` and `mem_irwrite`. A store interrupted during ACCESS may not complete, and no response is produced for it.

## Configuration
- **`MEMCTRL_ALIGN_CHECK_EN` defined:**
  - A request with `req_addr[1:0] != 0`, or with any `req_addr[31:ADDR_W+2]` bit set, is treated like a reserved op: error response, no strobe, 1-edge latency.
- **`MEMCTRL_ALIGN_CHECK_EN` undefined:**
  - Address low bits are ignored and upper bits are truncated.
  - Only op 11 produces an error.

## Test plan
- Assert `rst_n` low mid-ACCESS of a store → `mem_we` drops immediately. After release: `req_ready = 1`, `resp_valid = 0`, all other outputs 0.
- Store `0xDEADBEEF` to byte address `0x10` → `mem_we = 1` for exactly one cycle with `mem_addr = 4` and `mem_wd = 0xDEADBEEF`. `resp_valid` rises 3 edges after acceptance with `resp_data = 0` and `resp_err = 0`.
- Load byte address `0x10` against the memory model → `resp_data = 0xDEADBEEF`, no strobe asserted.
- Fetch byte address `0x0` → `mem_irwrite = 1` for one cycle and `resp_data` equals the memory model's word 0.
- Hold `resp_ready` low for 5 cycles after a load → `resp_valid` and `resp_data` remain stable, `req_ready` stays 0. Raising `resp_ready` returns to IDLE and `req_ready` rises the next cycle.
- Reserved op 11 → `resp_err = 1` after 1 edge with no strobe.
  - With `MEMCTRL_ALIGN_CHECK_EN` defined: loads to `0x13` and to `0x200` both give `resp_err = 1`.
  - With `MEMCTRL_ALIGN_CHECK_EN` undefined: a load to `0x13` accesses word 4 with `resp_err = 0`.
